// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the single-port RAM arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE} arb_state_t;
  typedef enum logic {OWN_IF, OWN_D} arb_owner_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Winner select between fetch and data requesters, with the data-streak
// counter that bounds how long a pending fetch can be starved.
module mem_arb_prio #(
  parameter int MAX_D_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic if_req,
  input  logic d_req,
  output logic if_win,
  output logic d_win
);

  localparam int STREAK_W = $clog2(MAX_D_BURST + 1);

  logic [STREAK_W-1:0] d_streak;
  logic                at_limit;

  assign at_limit = (d_streak == STREAK_W'(MAX_D_BURST));
  assign d_win    = en & d_req & ~(if_req & at_limit);
  assign if_win   = en & if_req & ~d_win;

  // The streak only matters while a fetch is waiting, so it resets whenever
  // the fetch side is idle or has just been served.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_streak <= '0;
    end else if (!if_req || if_win) begin
      d_streak <= '0;
    end else if (d_win && !at_limit) begin
      d_streak <= d_streak + STREAK_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the fetch and data ports.
// Define MEM_ARB_STATS_EN to build the grant/stall statistics counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int RD_LAT      = 2,
  parameter int MAX_D_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_w_en,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic [15:0]       stat_if_gnt,
  output logic [15:0]       stat_d_gnt,
  output logic [15:0]       stat_stall
);

  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  arb_state_t        state;
  arb_owner_t        owner;
  logic [LAT_W-1:0]  lat_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              arb_en;
  logic              if_win;
  logic              d_win;

  assign arb_en = (state == IDLE) && !rst;

  mem_arb_prio #(
    .MAX_D_BURST(MAX_D_BURST)
  ) u_prio (
    .clk   (clk),
    .rst   (rst),
    .en    (arb_en),
    .if_req(if_req),
    .d_req (d_req),
    .if_win(if_win),
    .d_win (d_win)
  );

  assign if_gnt    = if_win;
  assign d_gnt     = d_win;
  assign ram_w_en  = d_win & d_we;
  assign ram_wdata = ram_w_en ? d_wdata : '0;
  assign ram_addr  = d_win ? d_addr : (if_win ? if_addr : addr_q);
  assign busy      = (state != IDLE);

  // Stores complete in their grant cycle; reads park the FSM until the RAM
  // data is captured into the owning port's register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      lat_cnt   <= '0;
      addr_q    <= '0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (d_win) begin
            addr_q <= d_addr;
            if (!d_we) begin
              owner   <= OWN_D;
              lat_cnt <= LAT_W'(RD_LAT - 1);
              state   <= (RD_LAT == 1) ? RD_DONE : RD_WAIT;
            end
          end else if (if_win) begin
            addr_q  <= if_addr;
            owner   <= OWN_IF;
            lat_cnt <= LAT_W'(RD_LAT - 1);
            state   <= (RD_LAT == 1) ? RD_DONE : RD_WAIT;
          end
        end
        RD_WAIT: begin
          lat_cnt <= lat_cnt - LAT_W'(1);
          if (lat_cnt <= LAT_W'(1)) begin
            state <= RD_DONE;
          end
        end
        RD_DONE: begin
          if (owner == OWN_IF) begin
            if_rdata  <= ram_rdata;
            if_rvalid <= 1'b1;
          end else begin
            d_rdata  <= ram_rdata;
            d_rvalid <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [15:0] if_cnt;
  logic [15:0] d_cnt;
  logic [15:0] stall_cnt;
  logic        stalled;

  assign stalled = (if_req | d_req) & ~(if_win | d_win);

  // Saturating counters so a long run never wraps back to a small value.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_cnt    <= '0;
      d_cnt     <= '0;
      stall_cnt <= '0;
    end else begin
      if (if_win && if_cnt != 16'hFFFF)      if_cnt    <= if_cnt + 16'd1;
      if (d_win && d_cnt != 16'hFFFF)        d_cnt     <= d_cnt + 16'd1;
      if (stalled && stall_cnt != 16'hFFFF)  stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign stat_if_gnt = if_cnt;
  assign stat_d_gnt  = d_cnt;
  assign stat_stall  = stall_cnt;
`else
  assign stat_if_gnt = '0;
  assign stat_d_gnt  = '0;
  assign stat_stall  = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural 2-cycle RAM model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [10:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [10:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic [10:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_w_en;
  logic [31:0] ram_rdata;
  logic        busy;
  logic [15:0] stat_if_gnt;
  logic [15:0] stat_d_gnt;
  logic [15:0] stat_stall;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        if_q[$];
  exp_t        d_q[$];
  exp_t        mon_if_e;
  exp_t        mon_d_e;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          t;
  int          first_g;
  int          n_gnt;
  logic [31:0] mem [0:2047];
  logic [31:0] ram_p1;

  mem_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_w_en   (ram_w_en),
    .ram_rdata  (ram_rdata),
    .busy       (busy),
    .stat_if_gnt(stat_if_gnt),
    .stat_d_gnt (stat_d_gnt),
    .stat_stall (stat_stall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: address sampled at edge T, data visible during cycle T+2.
  always @(posedge clk) begin
    if (ram_w_en) mem[ram_addr] <= ram_wdata;
    ram_p1    <= mem[ram_addr];
    ram_rdata <= ram_p1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic ir, input logic [10:0] ia, input logic dr,
                               input logic dw, input logic [10:0] da, input logic [31:0] dd);
    @(posedge clk);
    #1;
    if_req  = ir;
    if_addr = ia;
    d_req   = dr;
    d_we    = dw;
    d_addr  = da;
    d_wdata = dd;
  endtask

  always @(negedge clk) begin
    if (if_rvalid) begin
      if (if_q.size() == 0) begin
        checkOutput("if_rvalid_unexpected", 32'd1, 32'd0);
      end else begin
        mon_if_e = if_q.pop_front();
        checkOutput("if_rdata", if_rdata, mon_if_e.data);
        checkOutput("if_rvalid_cycle", cyc, mon_if_e.cyc);
      end
    end
    if (d_rvalid) begin
      if (d_q.size() == 0) begin
        checkOutput("d_rvalid_unexpected", 32'd1, 32'd0);
      end else begin
        mon_d_e = d_q.pop_front();
        checkOutput("d_rdata", d_rdata, mon_d_e.data);
        checkOutput("d_rvalid_cycle", cyc, mon_d_e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'(i);
    mem[11'h010] = 32'hDEADBEEF;
    mem[11'h020] = 32'hCAFEF00D;
    mem[11'h030] = 32'h11112222;
    mem[11'h040] = 32'h40404040;
    mem[11'h050] = 32'h50505050;
    rst = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_if_gnt", if_gnt, 0);
    checkOutput("rst_d_gnt", d_gnt, 0);
    checkOutput("rst_if_rvalid", if_rvalid, 0);
    checkOutput("rst_d_rvalid", d_rvalid, 0);
    checkOutput("rst_if_rdata", if_rdata, 0);
    checkOutput("rst_d_rdata", d_rdata, 0);
    checkOutput("rst_ram_addr", ram_addr, 0);
    checkOutput("rst_ram_w_en", ram_w_en, 0);
    checkOutput("rst_stat_if", stat_if_gnt, 0);
    checkOutput("rst_stat_stall", stat_stall, 0);

    // single fetch read
    applyStimulus(1, 11'h010, 0, 0, 0, 0);
    @(negedge clk);
    t = cyc;
    checkOutput("t1_if_gnt", if_gnt, 1);
    checkOutput("t1_busy_grant", busy, 0);
    checkOutput("t1_ram_addr", ram_addr, 32'h010);
    if_q.push_back('{data: 32'hDEADBEEF, cyc: t + 3});
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t1_busy_t1", busy, 1);
    checkOutput("t1_hold_addr", ram_addr, 32'h010);
    @(negedge clk);
    checkOutput("t1_busy_t2", busy, 1);
    @(negedge clk);
    checkOutput("t1_busy_t3", busy, 0);

    // simultaneous requests: data first, fetch granted alongside d_rvalid
    applyStimulus(1, 11'h030, 1, 0, 11'h020, 0);
    @(negedge clk);
    t = cyc;
    checkOutput("t2_d_gnt", d_gnt, 1);
    checkOutput("t2_if_gnt_lose", if_gnt, 0);
    checkOutput("t2_ram_addr", ram_addr, 32'h020);
    d_q.push_back('{data: 32'hCAFEF00D, cyc: t + 3});
    applyStimulus(1, 11'h030, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t2_if_wait1", if_gnt, 0);
    @(negedge clk);
    checkOutput("t2_if_wait2", if_gnt, 0);
    @(negedge clk);
    checkOutput("t2_if_gnt", if_gnt, 1);
    checkOutput("t2_if_ram_addr", ram_addr, 32'h030);
    if_q.push_back('{data: 32'h11112222, cyc: cyc + 3});
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);

    // continuous data loads vs pending fetch: 4 D then 1 IF, repeating
    applyStimulus(1, 11'h050, 1, 0, 11'h040, 0);
    n_gnt = 0;
    first_g = 0;
    for (int k = 0; k < 100 && n_gnt < 10; k++) begin
      @(negedge clk);
      if (d_gnt || if_gnt) begin
        if (n_gnt == 0) first_g = cyc;
        checkOutput($sformatf("t3_g%0d_d", n_gnt), d_gnt, (n_gnt % 5) != 4);
        checkOutput($sformatf("t3_g%0d_if", n_gnt), if_gnt, (n_gnt % 5) == 4);
        checkOutput($sformatf("t3_g%0d_cycle", n_gnt), cyc - first_g, 3 * n_gnt);
        if (d_gnt) d_q.push_back('{data: 32'h40404040, cyc: cyc + 3});
        else       if_q.push_back('{data: 32'h50505050, cyc: cyc + 3});
        n_gnt++;
      end
    end
    checkOutput("t3_grant_count", n_gnt, 10);
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (4) @(negedge clk);

    // back-to-back stores, then read one back
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(0, 0, 1, 1, 11'(i), 32'hA0000000 + 32'(i));
      @(negedge clk);
      checkOutput($sformatf("t4_st%0d_gnt", i), d_gnt, 1);
      checkOutput($sformatf("t4_st%0d_w_en", i), ram_w_en, 1);
      checkOutput($sformatf("t4_st%0d_addr", i), ram_addr, 32'(i));
      checkOutput($sformatf("t4_st%0d_wdata", i), ram_wdata, 32'hA0000000 + 32'(i));
      checkOutput($sformatf("t4_st%0d_busy", i), busy, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t4_w_en_off", ram_w_en, 0);
    checkOutput("t4_no_d_rvalid", d_rvalid, 0);
    applyStimulus(0, 0, 1, 0, 11'h002, 0);
    @(negedge clk);
    checkOutput("t4_ld_gnt", d_gnt, 1);
    d_q.push_back('{data: 32'hA0000002, cyc: cyc + 3});
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);

    // reset during RD_WAIT drops the read
    applyStimulus(1, 11'h010, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t5_if_gnt", if_gnt, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t5_busy_before_rst", busy, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_if_rvalid", if_rvalid, 0);
    checkOutput("t5_if_rdata", if_rdata, 0);
    checkOutput("t5_d_rdata", d_rdata, 0);
    checkOutput("t5_ram_addr", ram_addr, 0);
    checkOutput("t5_stat_d", stat_d_gnt, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("t5_no_rvalid%0d", i), if_rvalid, 0);
    end

    // statistics: one fetch read, a load that stalls two cycles behind it
    applyStimulus(1, 11'h010, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t6_if_gnt", if_gnt, 1);
    if_q.push_back('{data: 32'hDEADBEEF, cyc: cyc + 3});
    applyStimulus(0, 0, 1, 0, 11'h020, 0);
    @(negedge clk);
    checkOutput("t6_stall1", d_gnt, 0);
    @(negedge clk);
    checkOutput("t6_stall2", d_gnt, 0);
    @(negedge clk);
    checkOutput("t6_d_gnt", d_gnt, 1);
    d_q.push_back('{data: 32'hCAFEF00D, cyc: cyc + 3});
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
`ifdef MEM_ARB_STATS_EN
    checkOutput("t6_stat_if", stat_if_gnt, 1);
    checkOutput("t6_stat_d", stat_d_gnt, 1);
    checkOutput("t6_stat_stall", stat_stall, 2);
`else
    checkOutput("t6_stat_if", stat_if_gnt, 0);
    checkOutput("t6_stat_d", stat_d_gnt, 0);
    checkOutput("t6_stat_stall", stat_stall, 0);
`endif

    repeat (3) @(negedge clk);
    checkOutput("if_queue_drained", if_q.size(), 0);
    checkOutput("d_queue_drained", d_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
